scene_sequencer: RTL and testbench

- Frame-synchronous controller that time-shares the RGB output between NUM_SCENES scene renderers (coin, etc.).
- Renderers run in parallel on the shared h_count/v_count; this block selects one, drives their `frame` parity bit, and fades between scenes.
- Sits between the scene renderers and the VGA output pins. Output is registered, 2 bits per channel.

---
 rtl/scene_sequencer.sv | 179 +++++++++++++++++
 tb/tb_scene_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/scene_sequencer.sv
// Frame-synchronous scene selector with optional fade-through-black between scenes.
// Define SCENE_SEQ_FADE_EN for fades; when it is undefined, scenes hard-cut on a frame boundary.
module scene_sequencer #(
  parameter int NUM_SCENES   = 4,
  parameter int DWELL_FRAMES = 240,
  parameter int STEP_FRAMES  = 4,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [10:0]             h_count,
  input  logic [9:0]              v_count,
  input  logic                    next_req,
  input  logic                    pause,
  input  logic [6*NUM_SCENES-1:0] scene_rgb,
  output logic                    frame,
  output logic [1:0]              scene_sel,
  output logic [2:0]              fade_level,
  output logic                    busy,
  output logic [1:0]              r_out,
  output logic [1:0]              g_out,
  output logic [1:0]              b_out
);

  localparam logic [1:0] ST_DWELL  = 2'd0;
  localparam logic [1:0] ST_SWITCH = 2'd2;
`ifdef SCENE_SEQ_FADE_EN
  localparam logic [1:0] ST_FADE_OUT = 2'd1;
  localparam logic [1:0] ST_FADE_IN  = 2'd3;
  localparam logic [3:0] STEP_LAST   = 4'(STEP_FRAMES - 1);
`endif
  localparam logic [9:0]  DWELL_LAST = 10'(DWELL_FRAMES - 1);
  localparam logic [1:0]  SCENE_LAST = 2'(NUM_SCENES - 1);
  localparam logic [10:0] H_LIMIT    = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIMIT    = 10'(V_ACTIVE);

  logic [1:0] state, state_nxt;
  logic [9:0] dwell_cnt, dwell_nxt;
  logic       pending, pending_nxt;
  logic [1:0] sel_nxt;
  logic       frame_tick;
`ifdef SCENE_SEQ_FADE_EN
  logic [3:0] step_cnt, step_nxt;
  logic [2:0] level_nxt;
`endif

  // Start of vertical blanking: the only instant scene/level may change.
  assign frame_tick = (h_count == 11'd0) && (v_count == V_LIMIT);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    dwell_nxt   = dwell_cnt;
    sel_nxt     = scene_sel;
    pending_nxt = pending | next_req;
`ifdef SCENE_SEQ_FADE_EN
    step_nxt    = step_cnt;
    level_nxt   = fade_level;
`endif
    if (frame_tick) begin
      case (state)
        ST_DWELL: begin
          if (pending || (dwell_cnt == DWELL_LAST && !pause)) begin
`ifdef SCENE_SEQ_FADE_EN
            state_nxt = ST_FADE_OUT;
`else
            state_nxt = ST_SWITCH;
`endif
            dwell_nxt   = '0;
            pending_nxt = 1'b0;   // a request on this same tick is absorbed
          end else if (!pause) begin
            dwell_nxt = dwell_cnt + 10'd1;
          end
        end
`ifdef SCENE_SEQ_FADE_EN
        ST_FADE_OUT: begin
          if (step_cnt == STEP_LAST) begin
            step_nxt  = '0;
            level_nxt = fade_level - 3'd1;
            if (fade_level == 3'd1) state_nxt = ST_SWITCH;
          end else begin
            step_nxt = step_cnt + 4'd1;
          end
        end
        ST_FADE_IN: begin
          if (step_cnt == STEP_LAST) begin
            step_nxt  = '0;
            level_nxt = fade_level + 3'd1;
            if (fade_level == 3'd3) state_nxt = ST_DWELL;
          end else begin
            step_nxt = step_cnt + 4'd1;
          end
        end
`endif
        ST_SWITCH: begin
          sel_nxt = (scene_sel == SCENE_LAST) ? 2'd0 : scene_sel + 2'd1;
`ifdef SCENE_SEQ_FADE_EN
          state_nxt = ST_FADE_IN;
`else
          state_nxt = ST_DWELL;
`endif
        end
        default: state_nxt = ST_DWELL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_DWELL;
      dwell_cnt <= '0;
      pending   <= 1'b0;
      scene_sel <= 2'd0;
      busy      <= 1'b0;
      frame     <= 1'b0;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
      pending   <= pending_nxt;
      scene_sel <= sel_nxt;
      busy      <= (state_nxt != ST_DWELL);
      if (frame_tick) frame <= ~frame;
    end
  end

`ifdef SCENE_SEQ_FADE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt   <= '0;
      fade_level <= 3'd4;
    end else begin
      step_cnt   <= step_nxt;
      fade_level <= level_nxt;
    end
  end
`else
  assign fade_level = 3'd4;
`endif

  // Colour path: pick the selected renderer, attenuate, blank outside the active area.
  logic [5:0] pix;
  logic       pixel_on;

  always_comb begin
    pix = '0;
    for (int k = 0; k < NUM_SCENES; k++) begin
      if (scene_sel == 2'(k)) pix = scene_rgb[6*k +: 6];
    end
  end

  assign pixel_on = (h_count < H_LIMIT) && (v_count < V_LIMIT);

  function automatic logic [1:0] scale(input logic [1:0] c, input logic [2:0] lvl);
    logic [4:0] prod;
    prod = {3'b000, c} * {2'b00, lvl};
    return 2'(prod >> 2);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= 2'd0;
      g_out <= 2'd0;
      b_out <= 2'd0;
    end else if (pixel_on) begin
      r_out <= scale(pix[5:4], fade_level);
      g_out <= scale(pix[3:2], fade_level);
      b_out <= scale(pix[1:0], fade_level);
    end else begin
      r_out <= 2'd0;
      g_out <= 2'd0;
      b_out <= 2'd0;
    end
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// Randomized scoreboard bench for scene_sequencer; honours SCENE_SEQ_FADE_EN like the DUT.
module tb_scene_sequencer;

  localparam int NS = 3;
  localparam int DW = 3;
  localparam int SF = 2;
  localparam int HA = 640;
  localparam int VA = 480;
  localparam logic [12:0] RST_VEC = {1'b0, 2'd0, 3'd4, 1'b0, 6'd0};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [10:0]   h_count = '0;
  logic [9:0]    v_count = '0;
  logic          next_req = 1'b0;
  logic          pause = 1'b0;
  logic [6*NS-1:0] scene_rgb = '0;
  logic          frame, busy;
  logic [1:0]    scene_sel, r_out, g_out, b_out;
  logic [2:0]    fade_level;
  logic [12:0]   dut_vec;

  always #5 clk = ~clk;

  scene_sequencer #(
    .NUM_SCENES(NS), .DWELL_FRAMES(DW), .STEP_FRAMES(SF), .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
    .next_req(next_req), .pause(pause), .scene_rgb(scene_rgb),
    .frame(frame), .scene_sel(scene_sel), .fade_level(fade_level), .busy(busy),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  assign dut_vec = {frame, scene_sel, fade_level, busy, r_out, g_out, b_out};

  // Reference model: per-frame view; a transition is a pre-computed script of
  // per-tick (level, scene advance, busy) entries.
  typedef struct { int level; bit inc; bit busy; } step_t;
  step_t       script[$];
  logic [12:0] exp_q[$];
  int n_vec = 0, n_bad = 0;
  bit started = 0;
  int m_frame, m_scene, m_level, m_busy, m_dwell, m_pending;
  int pause_mode = 0, req_pm = 0;
  bit last_tick;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got frame=%0d sel=%0d lvl=%0d busy=%0d rgb=%02h, want frame=%0d sel=%0d lvl=%0d busy=%0d rgb=%02h",
               name, $time, act[12], act[11:10], act[9:7], act[6], act[5:0],
               exp[12], exp[11:10], exp[9:7], exp[6], exp[5:0]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (started) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL scoreboard_underflow @%0t: got %h, want an expected entry", $time, dut_vec);
      end else begin
        check("cycle", dut_vec, exp_q.pop_front());
      end
    end
  end

  function automatic void model_reset();
    m_frame = 0; m_scene = 0; m_level = 4; m_busy = 0; m_dwell = 0; m_pending = 0;
    script.delete();
  endfunction

  function automatic void push_step(int lvl, bit inc, bit b);
    step_t s;
    s.level = lvl; s.inc = inc; s.busy = b;
    script.push_back(s);
  endfunction

  function automatic void start_transition();
`ifdef SCENE_SEQ_FADE_EN
    for (int l = 3; l >= 0; l--)
      for (int s = 0; s < SF; s++) push_step((s == SF-1) ? l : l+1, 1'b0, 1'b1);
    push_step(0, 1'b1, 1'b1);
    for (int l = 1; l <= 4; l++)
      for (int s = 0; s < SF; s++) push_step((s == SF-1) ? l : l-1, 1'b0, !(l == 4 && s == SF-1));
`else
    push_step(4, 1'b1, 1'b0);
`endif
  endfunction

  function automatic int atten(int c);
    return (c * m_level) / 4;
  endfunction

  task automatic drive_and_model();
    int hv, vv, sel, ch, er, eg, eb;
    bit active, leave;
    int hsel[3] = '{0, HA-1, HA};
    int vsel[3] = '{0, VA-1, VA};
    sel = $urandom_range(0, 99);
    if (sel < 16) begin hv = 0; vv = VA; end
    else if (sel < 24) begin hv = hsel[$urandom_range(0, 2)]; vv = vsel[$urandom_range(0, 2)]; end
    else begin hv = $urandom_range(0, 799); vv = $urandom_range(0, 524); end
    h_count   = 11'(hv);
    v_count   = 10'(vv);
    scene_rgb = (6*NS)'($urandom);
    next_req  = ($urandom_range(0, 999) < req_pm);
    pause     = (pause_mode == 2) ? ($urandom_range(0, 3) == 0) : (pause_mode == 1);

    active = (hv < HA) && (vv < VA);
    ch = int'((scene_rgb >> (6*m_scene)) & 6'h3f);
    er = active ? atten((ch >> 4) & 3) : 0;
    eg = active ? atten((ch >> 2) & 3) : 0;
    eb = active ? atten(ch & 3) : 0;

    last_tick = (hv == 0) && (vv == VA);
    leave = 0;
    if (last_tick) begin
      m_frame ^= 1;
      if (script.size() > 0) begin
        step_t e = script.pop_front();
        m_level = e.level;
        m_busy  = e.busy;
        if (e.inc) m_scene = (m_scene + 1) % NS;
      end else if (m_pending != 0 || (!pause && m_dwell == DW-1)) begin
        leave = 1; m_dwell = 0; m_busy = 1;
        start_transition();
      end else if (!pause) begin
        m_dwell++;
      end
    end
    m_pending = leave ? 0 : (m_pending | int'(next_req));

    exp_q.push_back({1'(m_frame), 2'(m_scene), 3'(m_level), 1'(m_busy), 2'(er), 2'(eg), 2'(eb)});
    started = 1;
  endtask

  task automatic cycle();
    @(negedge clk);
    drive_and_model();
  endtask

  // Caller is already at a falling edge.
  task automatic do_reset();
    rst_n = 1'b0; next_req = 1'b0; pause = 1'b0;
    #1;
    check("async_reset", dut_vec, RST_VEC);
    model_reset();
    exp_q.push_back(RST_VEC);
    @(negedge clk);
    exp_q.push_back(RST_VEC);
    @(negedge clk);
    rst_n = 1'b1;
    drive_and_model();
  endtask

  function automatic bit reset_point();
`ifdef SCENE_SEQ_FADE_EN
    return (m_busy != 0) && (m_level == 2);
`else
    return m_busy != 0;
`endif
  endfunction

  initial begin
    int ticks;
    bit hit;
    model_reset();
    @(negedge clk);
    #1;
    check("reset_initial", dut_vec, RST_VEC);
    rst_n = 1'b1;

    pause_mode = 0; req_pm = 5;
    repeat (2500) cycle();

    req_pm = 100;
    repeat (1500) cycle();

    pause_mode = 1; req_pm = 0;
    ticks = 0;
    for (int i = 0; i < 20000 && ticks < 500; i++) begin
      cycle();
      if (last_tick) ticks++;
    end
    if (ticks < 500) begin
      n_vec++; n_bad++;
      $display("FAIL pause_ticks: got %0d ticks, want 500", ticks);
    end

    pause_mode = 2; req_pm = 30;
    repeat (2000) cycle();

    pause_mode = 0; req_pm = 10;
    for (int r = 0; r < 4; r++) begin
      hit = 0;
      for (int i = 0; i < 3000 && !hit; i++) begin
        @(negedge clk);
        if (reset_point()) begin hit = 1; do_reset(); end
        else drive_and_model();
      end
      if (!hit) begin
        n_vec++; n_bad++;
        $display("FAIL reset_point_timeout: got none in 3000 cycles, want a busy frame");
      end
    end
    repeat (200) cycle();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    started = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
